alu_mul_seq: RTL and testbench

- Sequential unsigned multiplier that time-shares one ALU instance as its adder.
- Performs an N x N -> 2N shift-and-add multiply, one multiplier bit per cycle.
- Uses valid/ready handshakes on both input and output.
- Sits beside the single-cycle datapath as the multi-cycle MUL execution unit; the CPU control stalls on in_ready/out_valid.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu.sv | 43 ++++
 rtl/alu_mul_seq.sv | 126 ++++++++++++
 tb/tb_alu_mul_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcodes and the sequential multiplier's FSM state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU: add/sub/and/or/xor with carry, overflow, sign and zero flags.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    output logic [N-1:0] y,
    output logic         cf,
    output logic         of,
    output logic         sf,
    output logic         zero
);

    logic [N:0] ext;

    always_comb begin
        ext = '0;
        of  = 1'b0;
        unique case (op)
            ALU_ADD: begin
                ext = {1'b0, a} + {1'b0, b};
                of  = (a[N-1] == b[N-1]) && (ext[N-1] != a[N-1]);
            end
            ALU_SUB: begin
                // cf reports the borrow out of the subtraction
                ext = {1'b0, a} - {1'b0, b};
                of  = (a[N-1] != b[N-1]) && (ext[N-1] != a[N-1]);
            end
            ALU_AND: ext = {1'b0, a & b};
            ALU_OR:  ext = {1'b0, a | b};
            ALU_XOR: ext = {1'b0, a ^ b};
            default: ext = '0;
        endcase
        y    = ext[N-1:0];
        cf   = ext[N];
        sf   = ext[N-1];
        zero = (ext[N-1:0] == '0);
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential N x N -> 2N unsigned shift-and-add multiplier, one multiplier bit per cycle,
// reusing a single ALU instance as its adder. Valid/ready handshakes on both sides.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] prod_hi,
    output logic [N-1:0] prod_lo,
    output logic         zero,
    output logic         busy
);

    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    mul_state_e      state_q, state_d;
    logic [N-1:0]    mcand_q, mcand_d;
    logic [N-1:0]    acc_q, acc_d;
    logic [N-1:0]    mq_q, mq_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [N-1:0]    prod_hi_q, prod_lo_q;
    logic            zero_q;
    logic            load_prod;

    logic [N-1:0]    alu_b, alu_y;
    logic            alu_cf, alu_of, alu_sf, alu_zero;
    logic            unused_alu_flags;

    assign alu_b = mq_q[0] ? mcand_q : '0;

    alu #(
        .N(N)
    ) u_alu (
        .a   (acc_q),
        .b   (alu_b),
        .op  (ALU_ADD),
        .y   (alu_y),
        .cf  (alu_cf),
        .of  (alu_of),
        .sf  (alu_sf),
        .zero(alu_zero)
    );

    assign unused_alu_flags = alu_of ^ alu_sf ^ alu_zero;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        cnt_d     = cnt_q;
        load_prod = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mcand_d = a;
                    mq_d    = b;
                    acc_d   = '0;
                    cnt_d   = CntW'(N - 1);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // cf is the (N+1)th sum bit and lands in acc[N-1] after the shift
                {acc_d, mq_d} = {alu_cf, alu_y, mq_q[N-1:1]};
                cnt_d         = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d   = S_DONE;
                    load_prod = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            cnt_q   <= cnt_d;
        end
    end

    // Result registers hold the last product until the next one completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_hi_q <= '0;
            prod_lo_q <= '0;
            zero_q    <= 1'b0;
        end else if (load_prod) begin
            prod_hi_q <= acc_d;
            prod_lo_q <= mq_d;
            zero_q    <= ({acc_d, mq_d} == '0);
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_CALC);
    assign out_valid = (state_q == S_DONE);
    assign prod_hi   = prod_hi_q;
    assign prod_lo   = prod_lo_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed scenarios plus randomized operands
// checked against a plain 64-bit multiply reference.
module tb_alu_mul_seq;

    localparam int unsigned N = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] prod_hi;
    logic [N-1:0] prod_lo;
    logic         zero;
    logic         busy;

    int n_tests;
    int n_fail;

    alu_mul_seq #(
        .N(N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .prod_hi  (prod_hi),
        .prod_lo  (prod_lo),
        .zero     (zero),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        return {32'd0, x} * {32'd0, y};
    endfunction

    // Issue one operation from a negedge and wait (bounded) for out_valid.
    // lat = edges after the accept edge until out_valid is seen.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int calc_bad);
        int guard;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        guard    = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat      = 0;
        calc_bad = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) calc_bad++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #1 rst_n  = 1'b0;
        #2;
        n_tests++;
        if ({in_ready, out_valid, busy, zero} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 1000", {in_ready, out_valid, busy, zero});
        end
        n_tests++;
        if ({prod_hi, prod_lo} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_prod: got %h required 0", {prod_hi, prod_lo});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_directed(input string name, input logic [31:0] x, input logic [31:0] y,
                                 input logic [63:0] want, input logic want_zero);
        int lat, bad;
        out_ready = 1'b1;
        run_op(x, y, lat, bad);
        n_tests++;
        if (lat !== 32) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d required 32", name, lat);
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL %s_calc_flags: %0d bad cycles, required 0", name, bad);
        end
        n_tests++;
        if ({prod_hi, prod_lo} !== want) begin
            n_fail++;
            $display("FAIL %s_product: got %h required %h", name, {prod_hi, prod_lo}, want);
        end
        n_tests++;
        if (zero !== want_zero) begin
            n_fail++;
            $display("FAIL %s_zero: got %b required %b", name, zero, want_zero);
        end
        take();
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL %s_taken: got %b required 01", name, {out_valid, in_ready});
        end
    endtask

    task automatic test_backpressure();
        int lat, bad, hold_bad;
        out_ready = 1'b0;
        run_op(32'h0001_0000, 32'h0001_0000, lat, bad);
        n_tests++;
        if ({prod_hi, prod_lo} !== 64'h0000_0001_0000_0000) begin
            n_fail++;
            $display("FAIL bp_product: got %h required 0000000100000000", {prod_hi, prod_lo});
        end
        hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if ({out_valid, in_ready, busy} !== 3'b100 ||
                {prod_hi, prod_lo} !== 64'h0000_0001_0000_0000) hold_bad++;
            in_valid = i[0];
            a        = $urandom;
            b        = $urandom;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_tests++;
        if (hold_bad !== 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d bad cycles, required 0", hold_bad);
        end
        take();
        n_tests++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL bp_release: got %b required 010", {out_valid, in_ready, busy});
        end
        n_tests++;
        if ({prod_hi, prod_lo} !== 64'h0000_0001_0000_0000) begin
            n_fail++;
            $display("FAIL bp_retain: got %h required 0000000100000000", {prod_hi, prod_lo});
        end
    endtask

    task automatic test_reset_mid_calc();
        int lat, bad, stray;
        out_ready = 1'b1;
        a         = 32'hDEAD_BEEF;
        b         = 32'h89AB_CDEF;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, out_valid, busy, zero} !== 4'b1000) begin
            n_fail++;
            $display("FAIL midrst_flags: got %b required 1000", {in_ready, out_valid, busy, zero});
        end
        n_tests++;
        if ({prod_hi, prod_lo} !== 64'd0) begin
            n_fail++;
            $display("FAIL midrst_prod: got %h required 0", {prod_hi, prod_lo});
        end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) stray++;
        end
        n_tests++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL midrst_discard: %0d active cycles, required 0", stray);
        end
        run_op(32'd7, 32'd6, lat, bad);
        n_tests++;
        if (lat !== 32) begin
            n_fail++;
            $display("FAIL midrst_latency: got %0d required 32", lat);
        end
        n_tests++;
        if ({prod_hi, prod_lo} !== 64'd42) begin
            n_fail++;
            $display("FAIL midrst_product: got %h required 42", {prod_hi, prod_lo});
        end
        take();
    endtask

    task automatic test_back_to_back();
        int lat, extra;
        out_ready = 1'b1;
        a         = 32'd2;
        b         = 32'd3;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a   = 32'd4;
        b   = 32'd5;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        n_tests++;
        if (lat !== 32 || {prod_hi, prod_lo} !== 64'd6) begin
            n_fail++;
            $display("FAIL b2b_first: got lat %0d prod %h required lat 32 prod 6",
                     lat, {prod_hi, prod_lo});
        end
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL b2b_gap: got %b required 010", {out_valid, in_ready, busy});
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if ({in_ready, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_second_accept: got %b required 01", {in_ready, busy});
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        n_tests++;
        if (lat !== 32 || {prod_hi, prod_lo} !== 64'd20) begin
            n_fail++;
            $display("FAIL b2b_second: got lat %0d prod %h required lat 32 prod 20",
                     lat, {prod_hi, prod_lo});
        end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) extra++;
        end
        out_ready = 1'b0;
        n_tests++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL b2b_duplicate: %0d extra valid cycles, required 0", extra);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        int unsigned r;
        r = $urandom_range(0, 7);
        if (r == 0) return 32'd0;
        if (r == 1) return 32'hFFFF_FFFF;
        return $urandom;
    endfunction

    task automatic test_random();
        int lat, bad, waits;
        logic [31:0] x, y;
        logic [63:0] want;
        for (int i = 0; i < 24; i++) begin
            x         = pick_operand();
            y         = pick_operand();
            want      = model(x, y);
            out_ready = 1'b0;
            run_op(x, y, lat, bad);
            n_tests++;
            if (lat !== 32 || bad !== 0) begin
                n_fail++;
                $display("FAIL rand_timing[%0d]: got lat %0d bad %0d required lat 32 bad 0",
                         i, lat, bad);
            end
            n_tests++;
            if ({prod_hi, prod_lo} !== want || zero !== (want == 64'd0)) begin
                n_fail++;
                $display("FAIL rand_product[%0d]: %h*%h got %h z%b required %h z%b",
                         i, x, y, {prod_hi, prod_lo}, zero, want, (want == 64'd0));
            end
            waits = $urandom_range(0, 3);
            repeat (waits) @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || {prod_hi, prod_lo} !== want) begin
                n_fail++;
                $display("FAIL rand_hold[%0d]: got v%b %h required v1 %h",
                         i, out_valid, {prod_hi, prod_lo}, want);
            end
            take();
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_directed("basic", 32'd3, 32'd5, 64'd15, 1'b0);
        test_directed("carry", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
        test_directed("zero_op", 32'h1234_5678, 32'd0, 64'd0, 1'b1);
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
